// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage sitting in front of the processor control FSM.
// Owns the program counter and the instruction register. It fetches words from
// a variable-latency instruction memory and keeps one prefetched word
// (the word at the current PC) in a single-entry buffer.
//
// The control FSM drives three strobes:
//   PC_clr  clear PC, drop any buffered or in-flight word
//   PC_up   advance PC
//   IR_ld   load IR with the word at the current PC
//
// Ports
//   Clk      in   1   clock, rising edge
//   Reset    in   1   asynchronous, active-high reset
//   PC_clr   in   1   clear PC to 0 (highest priority strobe)
//   PC_up    in   1   advance PC by 1 (mod 2^AW)
//   IR_ld    in   1   load IR with the instruction at PC
//   I_Addr   out  AW  instruction memory address, stable while I_rd=1
//   I_rd     out  1   read request level, held until I_ack
//   I_rdata  in   DW  read data, valid with I_ack
//   I_ack    in   1   one-cycle read completion
//   PC       out  AW  program counter
//   IR       out  DW  instruction register
//   IR_valid out  1   IR loaded since last reset / PC_clr
//   Busy     out  1   an IR_ld is waiting for its word
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          PC_clr,
  input  logic          PC_up,
  input  logic          IR_ld,
  output logic [AW-1:0] I_Addr,
  output logic          I_rd,
  input  logic [DW-1:0] I_rdata,
  input  logic          I_ack,
  output logic [AW-1:0] PC,
  output logic [DW-1:0] IR,
  output logic          IR_valid,
  output logic          Busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FULL  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [AW-1:0] PC_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PC_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] IR_ZERO = {DW{1'b0}};

  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic [DW-1:0] r_ir;
  logic          r_ir_valid;
  logic [DW-1:0] r_buf;
  logic          r_ld_pend;
  logic          r_up_pend;
  logic [AW-1:0] r_addr;
  logic          r_rd;

  state_t        w_state_n;
  logic [AW-1:0] w_pc_n;
  logic [DW-1:0] w_ir_n;
  logic          w_ir_valid_n;
  logic [DW-1:0] w_buf_n;
  logic          w_ld_pend_n;
  logic          w_up_pend_n;
  logic [AW-1:0] w_addr_n;
  logic          w_rd_n;
  logic          w_new_req;
  logic          w_ack;
  logic          w_load_req;

  // An ack only counts while a request is actually on the bus.
  assign w_ack = I_ack & r_rd;

  // A load that is pending, or requested this cycle, outside FULL.
  assign w_load_req = r_ld_pend | IR_ld;

  // Next-state, datapath and request decode.
  always_comb begin
    w_state_n    = r_state;
    w_pc_n       = r_pc;
    w_ir_n       = r_ir;
    w_ir_valid_n = r_ir_valid;
    w_buf_n      = r_buf;
    w_ld_pend_n  = r_ld_pend;
    w_up_pend_n  = r_up_pend;
    w_addr_n     = r_addr;
    w_new_req    = 1'b0;

    if (PC_clr) begin
      w_pc_n       = PC_ZERO;
      w_ld_pend_n  = 1'b0;
      w_up_pend_n  = 1'b0;
      w_ir_valid_n = 1'b0;
      case (r_state)
        ST_REQ, ST_DRAIN: begin
          // An ack landing with the clear already retired the old request,
          // so the new one can go out straight away.
          if (w_ack) begin
            w_state_n = ST_REQ;
            w_new_req = 1'b1;
          end else begin
            w_state_n = ST_DRAIN;
          end
        end
        default: begin
          w_state_n = ST_REQ;
          w_new_req = 1'b1;
        end
      endcase
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_n = ST_REQ;
          w_new_req = 1'b1;
          if (IR_ld) begin
            w_ld_pend_n = 1'b1;
          end else begin
            w_ld_pend_n = r_ld_pend;
          end
          if (PC_up && w_load_req) begin
            w_up_pend_n = 1'b1;
          end else if (PC_up) begin
            w_pc_n = r_pc + PC_ONE;
          end else begin
            w_pc_n = r_pc;
          end
        end

        ST_REQ: begin
          if (w_ack) begin
            w_buf_n = I_rdata;
            if (w_load_req) begin
              w_ir_n       = I_rdata;
              w_ir_valid_n = 1'b1;
              w_ld_pend_n  = 1'b0;
            end else begin
              w_ld_pend_n  = r_ld_pend;
            end
            // A deferred or same-cycle increment moves on to the next word.
            if (r_up_pend || PC_up) begin
              w_pc_n      = r_pc + PC_ONE;
              w_up_pend_n = 1'b0;
              w_state_n   = ST_REQ;
              w_new_req   = 1'b1;
            end else begin
              w_state_n   = ST_FULL;
            end
          end else begin
            if (IR_ld) begin
              w_ld_pend_n = 1'b1;
            end else begin
              w_ld_pend_n = r_ld_pend;
            end
            if (PC_up && w_load_req) begin
              w_up_pend_n = 1'b1;
            end else if (PC_up) begin
              // Address already on the bus is now stale; drain it first.
              w_pc_n    = r_pc + PC_ONE;
              w_state_n = ST_DRAIN;
            end else begin
              w_state_n = ST_REQ;
            end
          end
        end

        ST_FULL: begin
          if (IR_ld) begin
            w_ir_n       = r_buf;
            w_ir_valid_n = 1'b1;
          end else begin
            w_ir_n       = r_ir;
          end
          if (PC_up) begin
            w_pc_n    = r_pc + PC_ONE;
            w_state_n = ST_REQ;
            w_new_req = 1'b1;
          end else begin
            w_state_n = ST_FULL;
          end
        end

        ST_DRAIN: begin
          if (IR_ld) begin
            w_ld_pend_n = 1'b1;
          end else begin
            w_ld_pend_n = r_ld_pend;
          end
          if (PC_up && w_load_req) begin
            w_up_pend_n = 1'b1;
          end else if (PC_up) begin
            w_pc_n = r_pc + PC_ONE;
          end else begin
            w_pc_n = r_pc;
          end
          // Stale data is dropped; re-issue at whatever PC is current then.
          if (w_ack) begin
            w_state_n = ST_REQ;
            w_new_req = 1'b1;
          end else begin
            w_state_n = ST_DRAIN;
          end
        end

        default: begin
          w_state_n = ST_IDLE;
        end
      endcase
    end

    // The address is latched only when a fresh request starts, so it is
    // stable for as long as I_rd stays high on that request.
    if (w_new_req) begin
      w_addr_n = w_pc_n;
    end else begin
      w_addr_n = r_addr;
    end

    w_rd_n = (w_state_n == ST_REQ) || (w_state_n == ST_DRAIN);
  end

  // State and datapath registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_pc       <= PC_ZERO;
      r_ir       <= IR_ZERO;
      r_ir_valid <= 1'b0;
      r_buf      <= IR_ZERO;
      r_ld_pend  <= 1'b0;
      r_up_pend  <= 1'b0;
      r_addr     <= PC_ZERO;
      r_rd       <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_pc       <= w_pc_n;
      r_ir       <= w_ir_n;
      r_ir_valid <= w_ir_valid_n;
      r_buf      <= w_buf_n;
      r_ld_pend  <= w_ld_pend_n;
      r_up_pend  <= w_up_pend_n;
      r_addr     <= w_addr_n;
      r_rd       <= w_rd_n;
    end
  end

  assign I_Addr   = r_addr;
  assign I_rd     = r_rd;
  assign PC       = r_pc;
  assign IR       = r_ir;
  assign IR_valid = r_ir_valid;
  assign Busy     = r_ld_pend;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed, self-checking bench for instr_fetch. Inputs change and outputs are
// sampled on the falling clock edge; the design updates on the rising edge.
// Memory responses are driven by hand with a chosen latency per scenario.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  logic        Clk;
  logic        Reset;
  logic        PC_clr;
  logic        PC_up;
  logic        IR_ld;
  logic [7:0]  I_Addr;
  logic        I_rd;
  logic [15:0] I_rdata;
  logic        I_ack;
  logic [7:0]  PC;
  logic [15:0] IR;
  logic        IR_valid;
  logic        Busy;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch #(.AW(8), .DW(16)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .PC_clr   (PC_clr),
    .PC_up    (PC_up),
    .IR_ld    (IR_ld),
    .I_Addr   (I_Addr),
    .I_rd     (I_rd),
    .I_rdata  (I_rdata),
    .I_ack    (I_ack),
    .PC       (PC),
    .IR       (IR),
    .IR_valid (IR_valid),
    .Busy     (Busy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge Clk);
  endtask

  // One-cycle ack with data; returns at the falling edge after it is sampled.
  task automatic ack_once(input logic [15:0] d);
    I_ack   = 1'b1;
    I_rdata = d;
    cyc();
    I_ack   = 1'b0;
    I_rdata = 16'h0000;
  endtask

  task automatic strobe(input logic up, input logic ld, input logic clr);
    PC_up  = up;
    IR_ld  = ld;
    PC_clr = clr;
    cyc();
    PC_up  = 1'b0;
    IR_ld  = 1'b0;
    PC_clr = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; PC_clr = 1'b0; PC_up = 1'b0; IR_ld = 1'b0;
    I_ack = 1'b0; I_rdata = 16'h0000;
    repeat (3) cyc();
    n_checks++; if (PC !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h want %h", PC, 8'h00); end
    n_checks++; if (IR !== 16'h0000) begin n_fail++; $display("FAIL reset_ir: got %h want %h", IR, 16'h0000); end
    n_checks++; if ({IR_valid, Busy, I_rd} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want %b", {IR_valid, Busy, I_rd}, 3'b000); end
    n_checks++; if (I_Addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h want %h", I_Addr, 8'h00); end
    Reset = 1'b0;
    cyc();
    n_checks++; if ({I_rd, I_Addr} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL first_req: got rd=%b addr=%h want rd=1 addr=00", I_rd, I_Addr); end
  endtask

  // L=1 fetch of mem[0], then a normal IR_ld+PC_up cycle.
  task automatic test_basic_fetch();
    ack_once(16'h1234);
    n_checks++; if ({I_rd, Busy} !== 2'b00) begin n_fail++; $display("FAIL full_idle_bus: got rd=%b busy=%b want 0 0", I_rd, Busy); end
    strobe(1'b1, 1'b1, 1'b0);
    n_checks++; if (IR !== 16'h1234) begin n_fail++; $display("FAIL basic_ir: got %h want %h", IR, 16'h1234); end
    n_checks++; if (IR_valid !== 1'b1) begin n_fail++; $display("FAIL basic_ir_valid: got %b want 1", IR_valid); end
    n_checks++; if (PC !== 8'h01) begin n_fail++; $display("FAIL basic_pc: got %h want %h", PC, 8'h01); end
    n_checks++; if ({I_rd, I_Addr} !== {1'b1, 8'h01}) begin n_fail++; $display("FAIL basic_next_req: got rd=%b addr=%h want rd=1 addr=01", I_rd, I_Addr); end
  endtask

  // Load deferred in REQ at PC=5, completed by a late ack.
  task automatic test_pending_load();
    // Walk PC 1 -> 5: each step is an L=1 ack then PC_up from FULL.
    for (int i = 0; i < 4; i++) begin
      ack_once(16'h0100);
      strobe(1'b1, 1'b0, 1'b0);
    end
    n_checks++; if ({I_rd, I_Addr, PC} !== {1'b1, 8'h05, 8'h05}) begin n_fail++; $display("FAIL walk_to_5: got rd=%b addr=%h pc=%h want 1 05 05", I_rd, I_Addr, PC); end
    strobe(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({Busy, I_rd, I_Addr, PC} !== {1'b1, 1'b1, 8'h05, 8'h05}) begin n_fail++; $display("FAIL pend_wait%0d: got busy=%b rd=%b addr=%h pc=%h want 1 1 05 05", i, Busy, I_rd, I_Addr, PC); end
      if (i < 2) cyc();
    end
    n_checks++; if (IR !== 16'h1234) begin n_fail++; $display("FAIL pend_ir_hold: got %h want %h", IR, 16'h1234); end
    ack_once(16'h3ABC);
    n_checks++; if (IR !== 16'h3ABC) begin n_fail++; $display("FAIL pend_ir: got %h want %h", IR, 16'h3ABC); end
    n_checks++; if ({Busy, IR_valid, PC} !== {1'b0, 1'b1, 8'h06}) begin n_fail++; $display("FAIL pend_done: got busy=%b v=%b pc=%h want 0 1 06", Busy, IR_valid, PC); end
    n_checks++; if ({I_rd, I_Addr} !== {1'b1, 8'h06}) begin n_fail++; $display("FAIL pend_next_req: got rd=%b addr=%h want 1 06", I_rd, I_Addr); end
  endtask

  // PC_clr in REQ at PC=9 with the ack still outstanding.
  task automatic test_clear_inflight();
    for (int i = 0; i < 3; i++) begin
      ack_once(16'h0200);
      strobe(1'b1, 1'b0, 1'b0);
    end
    n_checks++; if ({I_Addr, PC} !== {8'h09, 8'h09}) begin n_fail++; $display("FAIL walk_to_9: got addr=%h pc=%h want 09 09", I_Addr, PC); end
    strobe(1'b0, 1'b0, 1'b1);
    n_checks++; if ({PC, I_Addr, I_rd, IR_valid} !== {8'h00, 8'h09, 1'b1, 1'b0}) begin n_fail++; $display("FAIL clr_drain: got pc=%h addr=%h rd=%b v=%b want 00 09 1 0", PC, I_Addr, I_rd, IR_valid); end
    ack_once(16'hDEAD);
    n_checks++; if ({IR, IR_valid} !== {16'h3ABC, 1'b0}) begin n_fail++; $display("FAIL clr_stale: got ir=%h v=%b want 3abc 0", IR, IR_valid); end
    n_checks++; if ({I_rd, I_Addr} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL clr_new_req: got rd=%b addr=%h want 1 00", I_rd, I_Addr); end
    ack_once(16'h0001);
    strobe(1'b0, 1'b1, 1'b0);
    n_checks++; if ({IR, IR_valid, PC, I_rd} !== {16'h0001, 1'b1, 8'h00, 1'b0}) begin n_fail++; $display("FAIL clr_reload: got ir=%h v=%b pc=%h rd=%b want 0001 1 00 0", IR, IR_valid, PC, I_rd); end
  endtask

  // PC wraps 255 -> 0 on a normal fetch cycle.
  task automatic test_pc_wrap();
    // Now in FULL at PC=0; step 255 times to reach FULL at PC=255.
    for (int i = 0; i < 255; i++) begin
      strobe(1'b1, 1'b0, 1'b0);
      ack_once((i == 254) ? 16'hBEEF : 16'h0300);
    end
    n_checks++; if ({PC, I_rd} !== {8'hFF, 1'b0}) begin n_fail++; $display("FAIL wrap_pre: got pc=%h rd=%b want ff 0", PC, I_rd); end
    strobe(1'b1, 1'b1, 1'b0);
    n_checks++; if ({IR, PC} !== {16'hBEEF, 8'h00}) begin n_fail++; $display("FAIL wrap: got ir=%h pc=%h want beef 00", IR, PC); end
    n_checks++; if ({I_rd, I_Addr} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL wrap_req: got rd=%b addr=%h want 1 00", I_rd, I_Addr); end
  endtask

  // FULL with no strobes: bus idle, state stable, stray ack ignored.
  task automatic test_halt();
    ack_once(16'h0777);
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin I_ack = 1'b1; I_rdata = 16'hBAD0; end
      cyc();
      I_ack = 1'b0; I_rdata = 16'h0000;
      n_checks++; if ({I_rd, PC, IR} !== {1'b0, 8'h00, 16'hBEEF}) begin n_fail++; $display("FAIL halt_c%0d: got rd=%b pc=%h ir=%h want 0 00 beef", i, I_rd, PC, IR); end
    end
    strobe(1'b0, 1'b1, 1'b0);
    n_checks++; if (IR !== 16'h0777) begin n_fail++; $display("FAIL halt_buf: got %h want %h", IR, 16'h0777); end
  endtask

  // Reset during DRAIN with an ack arriving while reset is held.
  task automatic test_reset_drain();
    strobe(1'b1, 1'b0, 1'b0);
    strobe(1'b1, 1'b0, 1'b0);
    n_checks++; if ({PC, I_Addr, I_rd} !== {8'h02, 8'h01, 1'b1}) begin n_fail++; $display("FAIL drain_setup: got pc=%h addr=%h rd=%b want 02 01 1", PC, I_Addr, I_rd); end
    Reset = 1'b1;
    #1;
    n_checks++; if ({PC, IR, IR_valid, Busy, I_rd, I_Addr} !== {8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00}) begin n_fail++; $display("FAIL async_reset: got pc=%h ir=%h v=%b b=%b rd=%b addr=%h want all zero", PC, IR, IR_valid, Busy, I_rd, I_Addr); end
    I_ack = 1'b1; I_rdata = 16'hBAD1;
    cyc();
    cyc();
    Reset = 1'b0;
    cyc();
    I_ack = 1'b0; I_rdata = 16'h0000;
    n_checks++; if ({I_rd, I_Addr, IR, IR_valid} !== {1'b1, 8'h00, 16'h0000, 1'b0}) begin n_fail++; $display("FAIL post_reset_req: got rd=%b addr=%h ir=%h v=%b want 1 00 0000 0", I_rd, I_Addr, IR, IR_valid); end
    ack_once(16'h5A5A);
    strobe(1'b0, 1'b1, 1'b0);
    n_checks++; if ({IR, IR_valid, PC} !== {16'h5A5A, 1'b1, 8'h00}) begin n_fail++; $display("FAIL post_reset_fetch: got ir=%h v=%b pc=%h want 5a5a 1 00", IR, IR_valid, PC); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_pending_load();
    test_clear_inflight();
    test_pc_wrap();
    test_halt();
    test_reset_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
